// File: rtl/alu_ext_pkg.sv
// Shared opcode encodings (EXE_*_OP) and helpers for the EX-stage ALU and its mul/div unit.
package alu_ext_pkg;

  typedef logic [7:0] aluop_t;

  localparam aluop_t EXE_NOP_OP   = 8'b0000_0000;
  localparam aluop_t EXE_AND_OP   = 8'b0010_0100;
  localparam aluop_t EXE_OR_OP    = 8'b0010_0101;
  localparam aluop_t EXE_XOR_OP   = 8'b0010_0110;
  localparam aluop_t EXE_NOR_OP   = 8'b0010_0111;
  localparam aluop_t EXE_ANDI_OP  = 8'b0101_1001;
  localparam aluop_t EXE_ORI_OP   = 8'b0101_1010;
  localparam aluop_t EXE_XORI_OP  = 8'b0101_1011;
  localparam aluop_t EXE_LUI_OP   = 8'b0101_1100;
  localparam aluop_t EXE_SLL_OP   = 8'b0111_1100;
  localparam aluop_t EXE_SLLV_OP  = 8'b0000_0100;
  localparam aluop_t EXE_SRL_OP   = 8'b0000_0010;
  localparam aluop_t EXE_SRLV_OP  = 8'b0000_0110;
  localparam aluop_t EXE_SRA_OP   = 8'b0000_0011;
  localparam aluop_t EXE_SRAV_OP  = 8'b0000_0111;
  localparam aluop_t EXE_MFHI_OP  = 8'b0001_0000;
  localparam aluop_t EXE_MTHI_OP  = 8'b0001_0001;
  localparam aluop_t EXE_MFLO_OP  = 8'b0001_0010;
  localparam aluop_t EXE_MTLO_OP  = 8'b0001_0011;
  localparam aluop_t EXE_SLT_OP   = 8'b0010_1010;
  localparam aluop_t EXE_SLTU_OP  = 8'b0010_1011;
  localparam aluop_t EXE_SLTI_OP  = 8'b0101_0111;
  localparam aluop_t EXE_SLTIU_OP = 8'b0101_1000;
  localparam aluop_t EXE_ADD_OP   = 8'b0010_0000;
  localparam aluop_t EXE_ADDU_OP  = 8'b0010_0001;
  localparam aluop_t EXE_SUB_OP   = 8'b0010_0010;
  localparam aluop_t EXE_SUBU_OP  = 8'b0010_0011;
  localparam aluop_t EXE_ADDI_OP  = 8'b0101_0101;
  localparam aluop_t EXE_ADDIU_OP = 8'b0101_0110;
  localparam aluop_t EXE_MULT_OP  = 8'b0001_1000;
  localparam aluop_t EXE_MULTU_OP = 8'b0001_1001;
  localparam aluop_t EXE_DIV_OP   = 8'b0001_1010;
  localparam aluop_t EXE_DIVU_OP  = 8'b0001_1011;
  localparam aluop_t EXE_BEQ_OP   = 8'b0101_0001;
  localparam aluop_t EXE_LW_OP    = 8'b1110_0011;
  localparam aluop_t EXE_SW_OP    = 8'b1110_1011;

  function automatic logic is_muldiv(aluop_t op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/alu_ext_muldiv_iter.sv
// Iterative multiply/divide: one shift-add or restoring-subtract step per cycle on magnitudes,
// with the signs re-applied once the magnitude result is complete.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             flush,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             idle,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic             is_div, neg_a, neg_b;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo;

  logic             sgn_a, sgn_b, div_ge;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff, quo, rem;
  logic [2*WIDTH-1:0] prod;

  assign sgn_a = op_signed & a[WIDTH-1];
  assign sgn_b = op_signed & b[WIDTH-1];

  assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state  <= S_BUSY;
          cnt    <= '0;
          is_div <= op_div;
          neg_a  <= sgn_a;
          neg_b  <= sgn_b;
          opnd   <= sgn_b ? -b : b;
          acc_lo <= sgn_a ? -a : a;
          acc_hi <= '0;
        end
        S_BUSY: begin
          if (is_div) begin
            acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign idle = (state == S_IDLE);
  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

  // With a zero divisor every step subtracts nothing, so acc_hi ends up holding |a| again.
  assign prod = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo  = (opnd == '0) ? {WIDTH{1'b1}} : ((neg_a ^ neg_b) ? -acc_lo : acc_lo);
  assign rem  = neg_a ? -acc_hi : acc_hi;

  assign res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? quo : prod[WIDTH-1:0];

endmodule

// File: rtl/alu_ext.sv
// EX-stage ALU: combinational MIPS integer ops plus HI/LO registers fed by MTHI/MTLO
// and the iterative mul/div unit, which stalls the pipeline while it works.
module alu_ext
  import alu_ext_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   sa,
  input  logic [7:0]       op,
  input  logic             valid_i,
  input  logic             flush,
  output logic [WIDTH-1:0] y,
  output logic             overflow,
  output logic             zero,
  output logic             stall,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int LUI_SH = (WIDTH > 16) ? WIDTH - 16 : 0;

  logic [WIDTH-1:0] hi, lo, sum, diff, md_hi, md_lo;
  logic             md_start, md_idle, md_busy, md_done;

  assign sum  = a + b;
  assign diff = a - b;

  assign md_start = valid_i & is_muldiv(op) & md_idle & ~flush;
  // Reset and flush both have to drop stall immediately, without waiting for the FSM.
  assign stall    = resetn & ~flush & (md_start | md_busy);

  muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk       (clk),
    .resetn    (resetn),
    .start     (md_start),
    .flush     (flush),
    .op_div    ((op == EXE_DIV_OP) || (op == EXE_DIVU_OP)),
    .op_signed ((op == EXE_MULT_OP) || (op == EXE_DIV_OP)),
    .a         (a),
    .b         (b),
    .idle      (md_idle),
    .busy      (md_busy),
    .done      (md_done),
    .res_hi    (md_hi),
    .res_lo    (md_lo)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (md_done && !flush) begin
      hi <= md_hi;
      lo <= md_lo;
    end else if (valid_i && md_idle && !flush) begin
      if (op == EXE_MTHI_OP) hi <= a;
      if (op == EXE_MTLO_OP) lo <= a;
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

  always_comb begin
    y        = '0;
    overflow = 1'b0;
    case (op)
      EXE_AND_OP, EXE_ANDI_OP: y = a & b;
      EXE_OR_OP,  EXE_ORI_OP:  y = a | b;
      EXE_XOR_OP, EXE_XORI_OP: y = a ^ b;
      EXE_NOR_OP:              y = ~(a | b);
      EXE_LUI_OP:              y = b << LUI_SH;
      EXE_ADD_OP, EXE_ADDI_OP: begin
        y        = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      EXE_ADDU_OP, EXE_ADDIU_OP, EXE_LW_OP, EXE_SW_OP: y = sum;
      EXE_SUB_OP: begin
        y        = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      EXE_SUBU_OP, EXE_BEQ_OP:   y = diff;
      EXE_SLT_OP, EXE_SLTI_OP:   y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      EXE_SLTU_OP, EXE_SLTIU_OP: y = {{(WIDTH-1){1'b0}}, a < b};
      EXE_SLL_OP:  y = b << sa;
      EXE_SRL_OP:  y = b >> sa;
      EXE_SRA_OP:  y = $signed(b) >>> sa;
      EXE_SLLV_OP: y = b << a[SHW-1:0];
      EXE_SRLV_OP: y = b >> a[SHW-1:0];
      EXE_SRAV_OP: y = $signed(b) >>> a[SHW-1:0];
      EXE_MFHI_OP: y = hi;
      EXE_MFLO_OP: y = lo;
      default: ;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: tb/tb_alu_ext.sv
// Self-checking bench for alu_ext: directed vector table, randomized ops against a
// behavioural model, and hand-written mul/div, flush and reset sequences.
module tb_alu_ext;
  import alu_ext_pkg::*;

  logic        clk, resetn, valid_i, flush;
  logic [31:0] a, b, y, hi_o, lo_o;
  logic [4:0]  sa;
  logic [7:0]  op;
  logic        overflow, zero, stall;

  int total = 0;
  int bad   = 0;

  alu_ext #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .resetn(resetn), .a(a), .b(b), .sa(sa), .op(op),
    .valid_i(valid_i), .flush(flush), .y(y), .overflow(overflow), .zero(zero),
    .stall(stall), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    aluop_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] y;
    logic        ov;
  } vec_t;

  vec_t   vecs[12];
  aluop_t comb_ops[27];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void ref_alu(input aluop_t o, input logic [31:0] av, input logic [31:0] bv,
                                  input logic [4:0] s, output logic [31:0] yv, output logic ov);
    longint      r;
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    yv   = 32'h0;
    ov   = 1'b0;
    case (o)
      EXE_AND_OP, EXE_ANDI_OP: yv = av & bv;
      EXE_OR_OP,  EXE_ORI_OP:  yv = av | bv;
      EXE_XOR_OP, EXE_XORI_OP: yv = av ^ bv;
      EXE_NOR_OP:              yv = ~(av | bv);
      EXE_LUI_OP:              yv = {bv[15:0], 16'h0};
      EXE_ADD_OP, EXE_ADDI_OP, EXE_SUB_OP: begin
        r  = (o == EXE_SUB_OP) ? longint'(int'(av)) - longint'(int'(bv))
                               : longint'(int'(av)) + longint'(int'(bv));
        yv = r[31:0];
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      EXE_ADDU_OP, EXE_ADDIU_OP, EXE_LW_OP, EXE_SW_OP: yv = av + bv;
      EXE_SUBU_OP, EXE_BEQ_OP: yv = av - bv;
      EXE_SLT_OP, EXE_SLTI_OP:   yv = (int'(av) < int'(bv)) ? 32'd1 : 32'd0;
      EXE_SLTU_OP, EXE_SLTIU_OP: yv = (av < bv) ? 32'd1 : 32'd0;
      EXE_SLL_OP:  yv = bv << s;
      EXE_SRL_OP:  yv = bv >> s;
      EXE_SRA_OP:  yv = (bv >> s) | (bv[31] ? ~(ones >> s) : 32'h0);
      EXE_SLLV_OP: yv = bv << av[4:0];
      EXE_SRLV_OP: yv = bv >> av[4:0];
      EXE_SRAV_OP: yv = (bv >> av[4:0]) | (bv[31] ? ~(ones >> av[4:0]) : 32'h0);
      default: ;
    endcase
  endfunction

  function automatic void ref_md(input aluop_t o, input logic [31:0] av, input logic [31:0] bv,
                                 output logic [31:0] h, output logic [31:0] l);
    longint      sq, sr;
    logic [63:0] p;
    if (o == EXE_MULT_OP) begin
      p = longint'(int'(av)) * longint'(int'(bv));
      {h, l} = p;
    end else if (o == EXE_MULTU_OP) begin
      p = {32'h0, av} * {32'h0, bv};
      {h, l} = p;
    end else if (bv == 32'h0) begin
      l = 32'hFFFF_FFFF;
      h = av;
    end else if (o == EXE_DIV_OP) begin
      sq = longint'(int'(av)) / longint'(int'(bv));
      sr = longint'(int'(av)) % longint'(int'(bv));
      l  = sq[31:0];
      h  = sr[31:0];
    end else begin
      l = av / bv;
      h = av % bv;
    end
  endfunction

  task automatic applyStimulus(input aluop_t o, input logic [31:0] av, input logic [31:0] bv,
                               input logic [4:0] s);
    @(negedge clk);
    op = o; a = av; b = bv; sa = s;
    #1;
  endtask

  task automatic run_md(input aluop_t o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
    int n;
    valid_i = 1'b1;
    applyStimulus(o, av, bv, 5'd0);
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({nm, " stall cycles"}, 64'(n), 64'd33);
    applyStimulus(EXE_MFLO_OP, 32'h0, 32'h0, 5'd0);
    check({nm, " hi"}, 64'(hi_o), 64'(exp_hi));
    check({nm, " lo"}, 64'(lo_o), 64'(exp_lo));
    check({nm, " mflo"}, 64'(y), 64'(exp_lo));
    check({nm, " no restart"}, 64'(stall), 64'd0);
    applyStimulus(EXE_MFHI_OP, 32'h0, 32'h0, 5'd0);
    check({nm, " mfhi"}, 64'(y), 64'(exp_hi));
  endtask

  initial begin
    logic [31:0] ey, eh, el, ra, rb;
    logic        eov;
    aluop_t      ro;

    vecs[0]  = '{EXE_ADD_OP,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b1};
    vecs[1]  = '{EXE_ADDU_OP, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b0};
    vecs[2]  = '{EXE_SUB_OP,  32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 1'b1};
    vecs[3]  = '{EXE_SRA_OP,  32'h8000_0000, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0};
    vecs[4]  = '{EXE_SRLV_OP, 32'd36,        32'hF000_0000, 5'd0, 32'h0F00_0000, 1'b0};
    vecs[5]  = '{EXE_SLTU_OP, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0001, 1'b0};
    vecs[6]  = '{EXE_SLT_OP,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0};
    vecs[7]  = '{EXE_LUI_OP,  32'h0000_0000, 32'h0000_ABCD, 5'd0, 32'hABCD_0000, 1'b0};
    vecs[8]  = '{EXE_NOR_OP,  32'h0F0F_0000, 32'h00FF_00FF, 5'd0, 32'hF000_FF00, 1'b0};
    vecs[9]  = '{EXE_SUB_OP,  32'h0000_0001, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b0};
    vecs[10] = '{8'hFF,       32'h1234_5678, 32'h1111_1111, 5'd3, 32'h0000_0000, 1'b0};
    vecs[11] = '{EXE_ADDI_OP, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'h0000_0000, 1'b1};

    comb_ops = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_ANDI_OP, EXE_ORI_OP,
                 EXE_XORI_OP, EXE_LUI_OP, EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP,
                 EXE_SUB_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTI_OP, EXE_SLTU_OP, EXE_SLTIU_OP,
                 EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP, EXE_SLLV_OP, EXE_SRLV_OP, EXE_SRAV_OP,
                 EXE_LW_OP, EXE_SW_OP, EXE_BEQ_OP};

    resetn = 1'b0; valid_i = 1'b0; flush = 1'b0;
    op = EXE_NOP_OP; a = 32'h0; b = 32'h0; sa = 5'd0;
    #12;
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sa);
      check($sformatf("vec%0d y", i), 64'(y), 64'(vecs[i].y));
      check($sformatf("vec%0d ovf", i), 64'(overflow), 64'(vecs[i].ov));
      check($sformatf("vec%0d zero", i), 64'(zero), 64'(vecs[i].y == 32'h0));
    end

    for (int i = 0; i < 200; i++) begin
      ro = comb_ops[$urandom_range(0, 26)];
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      applyStimulus(ro, ra, rb, 5'($urandom_range(0, 31)));
      ref_alu(ro, ra, rb, sa, ey, eov);
      check($sformatf("rand%0d op%h y", i, ro), 64'(y), 64'(ey));
      check($sformatf("rand%0d op%h ovf", i, ro), 64'(overflow), 64'(eov));
      check($sformatf("rand%0d op%h zero", i, ro), 64'(zero), 64'(ey == 32'h0));
    end

    run_md(EXE_MULT_OP, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");
    run_md(EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
    run_md(EXE_DIVU_OP, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu 7/0");
    run_md(EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div minneg");

    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0:       ro = EXE_MULT_OP;
        1:       ro = EXE_MULTU_OP;
        2:       ro = EXE_DIV_OP;
        default: ro = EXE_DIVU_OP;
      endcase
      ra = $urandom;
      rb = (i == 6) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      ref_md(ro, ra, rb, eh, el);
      run_md(ro, ra, rb, eh, el, $sformatf("rmd%0d op%h", i, ro));
    end

    // Flush in the tenth BUSY cycle aborts the multiply and leaves HI/LO alone.
    valid_i = 1'b1;
    applyStimulus(EXE_MTHI_OP, 32'h1111_2222, 32'h0, 5'd0);
    applyStimulus(EXE_MTLO_OP, 32'h3333_4444, 32'h0, 5'd0);
    applyStimulus(EXE_MULTU_OP, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0);
    check("flush issue stall", 64'(stall), 64'd1);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush stall drop", 64'(stall), 64'd0);
    @(negedge clk);
    flush = 1'b0; valid_i = 1'b0; op = EXE_NOP_OP;
    #1;
    check("flush hi kept", 64'(hi_o), 64'h1111_2222);
    check("flush lo kept", 64'(lo_o), 64'h3333_4444);
    check("flush idle", 64'(stall), 64'd0);
    ref_md(EXE_MULTU_OP, 32'hCAFE_F00D, 32'h8765_4321, eh, el);
    run_md(EXE_MULTU_OP, 32'hCAFE_F00D, 32'h8765_4321, eh, el, "multu after flush");

    // Asynchronous reset in the middle of a divide.
    applyStimulus(EXE_MTHI_OP, 32'h0000_AAAA, 32'h0, 5'd0);
    applyStimulus(EXE_MTLO_OP, 32'h0000_5555, 32'h0, 5'd0);
    applyStimulus(EXE_DIV_OP, 32'd100, 32'd3, 5'd0);
    repeat (5) @(negedge clk);
    #2;
    check("pre-reset stall", 64'(stall), 64'd1);
    resetn = 1'b0;
    #1;
    check("async reset stall", 64'(stall), 64'd0);
    check("async reset hi", 64'(hi_o), 64'd0);
    check("async reset lo", 64'(lo_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1; op = EXE_MTHI_OP; a = 32'h0000_1234;
    @(negedge clk);
    op = EXE_NOP_OP;
    #1;
    check("mthi after reset", 64'(hi_o), 64'h0000_1234);
    check("lo after reset", 64'(lo_o), 64'd0);
    check("idle after reset", 64'(stall), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
